// File: rtl/bht_table.sv
// ---------------------------------------------------------------------------
// bht_table -- PC-indexed branch history table of saturating counters.
//
// Sits beside fetch: a lookup presented on pred_* returns a registered
// prediction one cycle later. Execute writes resolved outcomes back through
// the update_* port. After reset an internal sweep clears every entry to
// strong not-taken before ready rises and traffic is accepted.
//
// Parameters
//   INDEX_W : table index width, ENTRIES = 2**INDEX_W
//   CTR_W   : saturating counter width (>=1), MSB=1 predicts taken
//   PC_W    : program counter width (>= INDEX_W+2)
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst            in   synchronous reset, active-high
//   ready          out  table initialised, lookups/updates accepted
//   pred_valid     in   lookup request this cycle
//   pred_pc        in   PC of the fetched instruction
//   pred_out_valid out  registered: prediction below is valid
//   pred_taken     out  registered predicted direction
//   pred_ctr       out  registered counter value behind the prediction
//   pred_hist      out  (GSHARE_EN) global history used by the lookup
//   update_valid   in   resolved branch writeback
//   update_pc      in   PC of the resolved branch
//   update_taken   in   actual branch outcome
//   update_hist    in   (GSHARE_EN) history the branch was predicted with
//
// Optional feature: define GSHARE_EN to XOR an INDEX_W-bit global history
// register into both lookup and update indices (gshare indexing).
// ---------------------------------------------------------------------------
module bht_table #(
  parameter int INDEX_W = 6,
  parameter int CTR_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               pred_valid,
  input  logic [PC_W-1:0]    pred_pc,
  output logic               pred_out_valid,
  output logic               pred_taken,
  output logic [CTR_W-1:0]   pred_ctr,
`ifdef GSHARE_EN
  output logic [INDEX_W-1:0] pred_hist,
  input  logic [INDEX_W-1:0] update_hist,
`endif
  input  logic               update_valid,
  input  logic [PC_W-1:0]    update_pc,
  input  logic               update_taken
);

  localparam int              ENTRIES = 1 << INDEX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // ST_RESET is only the power-up encoding; rst always lands in ST_INIT.
  typedef enum logic [1:0] {
    ST_RESET,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t             state, state_nx;
  logic [INDEX_W-1:0] ptr, ptr_nx;

  logic [CTR_W-1:0]   table_q [ENTRIES];

  logic [INDEX_W-1:0] lk_idx, upd_idx;
  logic               lk_fire, upd_fire, sweep_we;
  logic [CTR_W-1:0]   upd_cur, upd_nx, lk_ctr;

  // Index bits outside [INDEX_W+1:2] are deliberately ignored.
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, update_pc};

  // -------------------------------------------------------------------------
  // Init / run controller
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      ST_RESET: begin
        state_nx = ST_INIT;
        ptr_nx   = '0;
      end
      ST_INIT: begin
        ptr_nx = ptr + INDEX_W'(1);
        // The edge that clears the last entry also opens the table.
        if (&ptr) state_nx = ST_RUN;
      end
      ST_RUN: begin
        state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_INIT;
        ptr_nx   = '0;
      end
    endcase
  end

  // state is a register, so ready is glitch-free.
  assign ready    = (state == ST_RUN);
  assign sweep_we = (state == ST_INIT) && !rst;
  assign lk_fire  = ready && pred_valid && !rst;
  assign upd_fire = ready && update_valid && !rst;

  // -------------------------------------------------------------------------
  // Indexing (optionally hashed with global history)
  // -------------------------------------------------------------------------
`ifdef GSHARE_EN
  logic [INDEX_W-1:0] ghr;

  always_ff @(posedge clk) begin
    if (rst || state == ST_INIT) begin
      ghr <= '0;
    end else if (upd_fire) begin
      ghr <= (ghr << 1) | INDEX_W'(update_taken);
    end
  end

  assign lk_idx  = pred_pc[INDEX_W+1:2] ^ ghr;
  assign upd_idx = update_pc[INDEX_W+1:2] ^ update_hist;
`else
  assign lk_idx  = pred_pc[INDEX_W+1:2];
  assign upd_idx = update_pc[INDEX_W+1:2];
`endif

  // -------------------------------------------------------------------------
  // Saturating counter update
  // -------------------------------------------------------------------------
  assign upd_cur = table_q[upd_idx];

  always_comb begin
    upd_nx = upd_cur;
    if (update_taken) begin
      if (upd_cur != CTR_MAX) upd_nx = upd_cur + CTR_W'(1);
    end else begin
      if (upd_cur != '0) upd_nx = upd_cur - CTR_W'(1);
    end
  end

  // Write-first bypass: a lookup colliding with this cycle's update sees
  // the value being written, so fetch never predicts from stale state.
  assign lk_ctr = (upd_fire && (upd_idx == lk_idx)) ? upd_nx : table_q[lk_idx];

  // -------------------------------------------------------------------------
  // Counter storage: cleared by the sweep, written by updates only
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing it is the sweep's job,
  // which keeps it a plain RAM rather than a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      table_q[ptr] <= '0;
    end else if (upd_fire) begin
      table_q[upd_idx] <= upd_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Registered prediction; direction and counter hold when idle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_ctr       <= '0;
`ifdef GSHARE_EN
      pred_hist      <= '0;
`endif
    end else begin
      pred_out_valid <= lk_fire;
      if (lk_fire) begin
        pred_ctr   <= lk_ctr;
        pred_taken <= lk_ctr[CTR_W-1];
`ifdef GSHARE_EN
        pred_hist  <= ghr;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bht_table.sv
// ---------------------------------------------------------------------------
// tb_bht_table -- directed self-checking bench for bht_table (default
// parameters: 64 entries, 2-bit counters, 32-bit PC).
// ---------------------------------------------------------------------------
module tb_bht_table;

  localparam int INDEX_W = 6;
  localparam int CTR_W   = 2;
  localparam int PC_W    = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               ready;
  logic               pred_valid;
  logic [PC_W-1:0]    pred_pc;
  logic               pred_out_valid;
  logic               pred_taken;
  logic [CTR_W-1:0]   pred_ctr;
  logic               update_valid;
  logic [PC_W-1:0]    update_pc;
  logic               update_taken;
`ifdef GSHARE_EN
  logic [INDEX_W-1:0] pred_hist;
  logic [INDEX_W-1:0] update_hist = '0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bht_table #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_out_valid (pred_out_valid),
    .pred_taken     (pred_taken),
    .pred_ctr       (pred_ctr),
`ifdef GSHARE_EN
    .pred_hist      (pred_hist),
    .update_hist    (update_hist),
`endif
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input int exp_ctr, input logic exp_taken);
    pred_valid = 1'b1;
    pred_pc    = pc;
    tick();
    pred_valid = 1'b0;
    check({tag, ".valid"}, pred_out_valid, 1);
    check({tag, ".ctr"},   pred_ctr, exp_ctr);
    check({tag, ".taken"}, pred_taken, exp_taken);
  endtask

  // Count edges after rst drops until ready rises; bounded.
  task automatic sweep_wait(input string tag);
    int   n   = 0;
    logic saw = 1'b0;
    while (!ready && n < 200) begin
      tick();
      n++;
      if (pred_out_valid) saw = 1'b1;
    end
    check({tag, ".edges"}, n, 64);
    check({tag, ".no_pred"}, saw, 0);
  endtask

  initial begin
    rst          = 1'b1;
    pred_valid   = 1'b1;
    pred_pc      = '0;
    update_valid = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;

    // ---- reset sweep ----
    repeat (3) tick();
    check("rst.ready", ready, 0);
    check("rst.pov",   pred_out_valid, 0);
    check("rst.ctr",   pred_ctr, 0);
    check("rst.taken", pred_taken, 0);
`ifdef GSHARE_EN
    check("rst.hist",  pred_hist, 0);
`endif
    rst = 1'b0;
    sweep_wait("sweep");
    tick();
    check("first.pov",   pred_out_valid, 1);
    check("first.ctr",   pred_ctr, 0);
    check("first.taken", pred_taken, 0);
    pred_valid = 1'b0;
    for (int i = 0; i < 64; i++) lookup($sformatf("clr%0d", i), i * 4, 0, 1'b0);

    // ---- saturation up at idx 16 ----
    update(32'h40, 1'b1); lookup("up1", 32'h40, 1, 1'b0);
    update(32'h40, 1'b1); lookup("up2", 32'h40, 2, 1'b1);
    update(32'h40, 1'b1); lookup("up3", 32'h40, 3, 1'b1);
    update(32'h40, 1'b1); lookup("up4", 32'h40, 3, 1'b1);
    lookup("nbr17", 32'h44, 0, 1'b0);

    // ---- saturation down / hysteresis ----
    update(32'h40, 1'b0); lookup("dn1", 32'h40, 2, 1'b1);
    update(32'h40, 1'b1); lookup("dn2", 32'h40, 3, 1'b1);
    update(32'h40, 1'b0); lookup("dn3", 32'h40, 2, 1'b1);
    update(32'h40, 1'b0); lookup("dn4", 32'h40, 1, 1'b0);
    update(32'h40, 1'b0); update(32'h40, 1'b0);
    lookup("floor", 32'h40, 0, 1'b0);

    // ---- aliasing and alignment ----
    update(32'h100, 1'b1); update(32'h100, 1'b1);
    lookup("alias102", 32'h102, 2, 1'b1);
    lookup("alias200", 32'h200, 2, 1'b1);
    lookup("alias104", 32'h104, 0, 1'b0);

    // ---- bypass at idx 5 ----
    update(32'h14, 1'b1);
    update_valid = 1'b1; update_pc = 32'h14; update_taken = 1'b1;
    lookup("bypass", 32'h14, 2, 1'b1);
    update_valid = 1'b0;
    // different indices in the same cycle stay independent
    update_valid = 1'b1; update_pc = 32'h14; update_taken = 1'b1;
    lookup("indep", 32'h18, 0, 1'b0);
    update_valid = 1'b0;
    lookup("idx5", 32'h14, 3, 1'b1);
    // idle cycle: valid drops, direction and counter hold
    tick();
    check("hold.pov",   pred_out_valid, 0);
    check("hold.ctr",   pred_ctr, 3);
    check("hold.taken", pred_taken, 1);

    // ---- reset mid-run with an outstanding lookup ----
    update(32'h40, 1'b1); update(32'h40, 1'b1); update(32'h40, 1'b1);
    lookup("train16", 32'h40, 3, 1'b1);
    pred_valid = 1'b1; pred_pc = 32'h40; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.pov",   pred_out_valid, 0);
    check("midrst.ready", ready, 0);
    // traffic during the sweep must be ignored
    update_valid = 1'b1; update_pc = 32'h44; update_taken = 1'b1;
    sweep_wait("resweep");
    update_valid = 1'b0;
    pred_valid   = 1'b0;
    tick();
    lookup("post16", 32'h40, 0, 1'b0);
    lookup("post17", 32'h44, 0, 1'b0);
`ifdef GSHARE_EN
    check("post.hist", pred_hist, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
